// File: rtl/uart_mmio_pkg.sv
// Shared register map, bit positions and FSM states for uart_mmio_fifo.
// Optional irq output is built when UART_MMIO_IRQ_EN is defined.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    DATA_REG   = 2'd0,
    STATUS_REG = 2'd1,
    CTRL_REG   = 2'd2
  } reg_idx_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_TX_DROP    = 5;
  localparam int ST_TX_CNT     = 8;
  localparam int ST_RX_CNT     = 16;
  localparam int ST_CNT_W      = 8;

  localparam int CTRL_RX_IRQ  = 0;
  localparam int CTRL_TX_IRQ  = 1;
  localparam int CTRL_ERR_IRQ = 2;
  localparam int CTRL_W       = 3;

  function automatic int data_valid_bit(input int wl);
    return wl - 1;
  endfunction

endpackage

// File: rtl/uart_mmio_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with binary pointers.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// FIFO-buffered memory-mapped UART slave driving a uart_lite core.
// Define UART_MMIO_IRQ_EN to build the registered interrupt request.
module uart_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter int WL        = 32,
  parameter int ADDR_WL   = 2,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic                 cmd_wr,
  input  logic [ADDR_WL+1:0]   cmd_addr,
  input  logic [WL-1:0]        cmd_wdata,
  output logic                 rsp_valid,
  output logic [WL-1:0]        rsp_rdata,
  input  logic                 tx_rdy,
  output logic                 tx_vld,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 irq
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int VBIT  = data_valid_bit(WL);

  logic               rd;
  logic               wr;
  logic [ADDR_WL-1:0] idx;
  logic               sel_data;
  logic               sel_status;
  logic               sel_ctrl;

  logic                 tx_push;
  logic                 tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full;
  logic                 tx_empty;
  logic [TX_CW-1:0]     tx_count;

  logic                 rx_pop;
  logic [DATA_BITS-1:0] rx_head;
  logic                 rx_full;
  logic                 rx_empty;
  logic [RX_CW-1:0]     rx_count;

  logic [CTRL_W-1:0] ctrl;
  logic              rx_overrun;
  logic              tx_drop;
  logic              ov_set;
  logic              drop_set;
  logic              w1c;
  logic [WL-1:0]     rdata;

  tx_state_e state;
  tx_state_e state_nx;

  logic unused;

  assign rd         = cmd_valid && !cmd_wr;
  assign wr         = cmd_valid && cmd_wr;
  assign idx        = cmd_addr[ADDR_WL+1:2];
  assign sel_data   = (idx == ADDR_WL'(DATA_REG));
  assign sel_status = (idx == ADDR_WL'(STATUS_REG));
  assign sel_ctrl   = (idx == ADDR_WL'(CTRL_REG));

  // TX full rejects the push even if the drain pops this cycle.
  assign tx_push  = wr && sel_data && !tx_full;
  assign drop_set = wr && sel_data && tx_full;
  assign rx_pop   = rd && sel_data && !rx_empty;
  assign ov_set   = rx_valid && rx_full && !rx_pop;
  assign w1c      = wr && sel_status;
  assign unused   = ^{cmd_addr[1:0], cmd_wdata};

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (cmd_wdata[DATA_BITS-1:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_pop   = 1'b0;
    unique case (state)
      TX_IDLE: begin
        if (tx_rdy && !tx_empty) begin
          state_nx = TX_SEND;
          tx_pop   = 1'b1;
        end
      end
      TX_SEND: state_nx = TX_IDLE;
      default: state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_vld  <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_vld <= tx_pop;
      if (tx_pop) tx_data <= tx_head;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_data: begin
        if (!rx_empty) begin
          rdata[DATA_BITS-1:0] = rx_head;
          rdata[VBIT]          = 1'b1;
        end
      end
      sel_status: begin
        rdata[ST_TX_EMPTY]   = tx_empty;
        rdata[ST_TX_FULL]    = tx_full;
        rdata[ST_RX_EMPTY]   = rx_empty;
        rdata[ST_RX_FULL]    = rx_full;
        rdata[ST_RX_OVERRUN] = rx_overrun;
        rdata[ST_TX_DROP]    = tx_drop;
        rdata[ST_TX_CNT +: ST_CNT_W] = ST_CNT_W'(tx_count);
        rdata[ST_RX_CNT +: ST_CNT_W] = ST_CNT_W'(rx_count);
      end
      sel_ctrl: rdata[CTRL_W-1:0] = ctrl;
      default:  rdata = '0;
    endcase
  end

  // Sticky set dominates a same-cycle W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl       <= '0;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      if (wr && sel_ctrl) ctrl <= cmd_wdata[CTRL_W-1:0];
      rx_overrun <= ov_set |
        (rx_overrun & ~(w1c & cmd_wdata[ST_RX_OVERRUN]));
      tx_drop <= drop_set |
        (tx_drop & ~(w1c & cmd_wdata[ST_TX_DROP]));
      rsp_valid <= rd;
      if (rd) rsp_rdata <= rdata;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  logic irq_nx;

  assign irq_nx =
    (ctrl[CTRL_RX_IRQ] && !rx_empty) ||
    (ctrl[CTRL_TX_IRQ] && tx_empty) ||
    (ctrl[CTRL_ERR_IRQ] && (rx_overrun || tx_drop));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_nx;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: doc/uart_mmio_fifo.md
Name: uart_mmio_fifo

Overview:
Memory-mapped UART peripheral that generalises the single-flag UART0 register pair into a FIFO-buffered slave.
- Sits on the data-bus IO decode, alongside the other IO registers, and drives an external uart_lite instance.
- Parametrised TX/RX FIFOs, status, control and sticky error flags decouple CPU polling from the baud rate.
- Provides an optional interrupt request.

Parameters:
WL, 32, bus data width in bits; must be at least 24 so STATUS fits.
ADDR_WL, 2, word-address width of the local register space; 4 words are decoded.
TX_DEPTH, 16, TX FIFO depth in entries; power of two, 2..128.
RX_DEPTH, 16, RX FIFO depth in entries; power of two, 2..128.
DATA_BITS, 8, UART character width; at most 8.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  bus command strobe, qualified by the upstream IO select
cmd_wr  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WL+2  byte address; bits [ADDR_WL+1:2] select the register
cmd_wdata  in  WL  write data
rsp_valid  out  1  read data valid
rsp_rdata  out  WL  read data
tx_rdy  in  1  uart_lite transmitter idle
tx_vld  out  1  one-cycle character strobe to uart_lite
tx_data  out  DATA_BITS  character to transmit
rx_valid  in  1  uart_lite received-character strobe
rx_data  in  DATA_BITS  received character
irq  out  1  interrupt request, level

Behaviour:
- Reset (async, active-high):
  - both FIFOs empty; CTRL = 0; sticky flags = 0.
  - rsp_valid, rsp_rdata, tx_vld, tx_data and irq all 0.
- Register map (word index):
  - 0 DATA:
    - Write pushes cmd_wdata[DATA_BITS-1:0] into TX.
    - Read returns {bit WL-1 = 1, zeros, RX head} and pops RX.
    - Read with RX empty returns 0 and does not pop.
  - 1 STATUS:
    - Read fields: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] rx_overrun, [5] tx_drop, [15:8] tx_count, [23:16] rx_count. Counts are zero-extended.
    - Write: W1C on bits 4 and 5; other bits are ignored.
  - 2 CTRL: R/W. [0] rx_irq_en, [1] tx_irq_en, [2] err_irq_en.
  - 3: reserved. Reads return 0; writes are ignored.
- Read latency:
  - rsp_valid is a registered 1-cycle pulse, the cycle after cmd_valid && !cmd_wr.
  - rsp_rdata is captured in that same edge and held until the next read.
  - The RX pop takes effect at that same edge.
  - Writes produce no response.
- TX full:
  - A DATA write is dropped and sets tx_drop.
  - FIFO contents are unchanged.
- RX full:
  - rx_valid without a simultaneous pop drops the character and sets rx_overrun.
  - rx_valid in the same cycle as a DATA-read pop is accepted; the count is unchanged.
- TX drain, two-state FSM:
  - IDLE -> SEND when tx_rdy && !tx_empty. On that edge: tx_vld <= 1, tx_data <= head, pop.
  - SEND -> IDLE unconditionally next cycle with tx_vld <= 0. Back-to-back strobes are therefore impossible.
  - tx_data holds its value after the strobe.
- Simultaneous TX push (CPU) and pop (drain):
  - Both take effect; the count is unchanged.
  - When TX is full, the push is still rejected, even if a pop occurs in the same cycle.
- Sticky flags:
  - A set and a W1C clear in the same cycle: the set wins.
- FIFO pointers:
  - Binary pointers are $clog2(depth) bits and wrap naturally.
  - Count is $clog2(depth)+1 bits; full = (count == depth).
- Reset mid-character: the FIFOs are flushed. The uart_lite shares the reset and aborts its own transfer.

Optional Feature:
Macro UART_MMIO_IRQ_EN.
- Defined:
  - irq is registered and equals (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty) || (err_irq_en && (rx_overrun || tx_drop)).
  - It updates one cycle after any source changes.
- Undefined:
  - irq is tied to 0.
  - CTRL still reads and writes normally, with no effect.

Decomposition:
- Package uart_mmio_pkg holds:
  - register-index enum: DATA_REG = 0, STATUS_REG = 1, CTRL_REG = 2;
  - STATUS and CTRL bit-position localparams;
  - DATA valid-bit position.
- Sub-module sync_fifo, parametrised by WIDTH and DEPTH. It is instantiated twice and exposes:
  - push, pop, din and dout;
  - full, empty and count.
  - dout is first-word-fall-through.

Test Plan:
- Write 0x41, 0x42, 0x43 to DATA with tx_rdy held at 1 -> three tx_vld pulses carrying 0x41, 0x42, 0x43, each separated by at least one idle cycle; STATUS[0] = 1 afterwards.
- Hold tx_rdy = 0 and write 17 bytes (depth 16) -> STATUS shows tx_full = 1, tx_count = 16, tx_drop = 1; writing 0x20 to STATUS clears tx_drop.
- Inject 0x55 via rx_valid, then read DATA -> rsp_valid one cycle later, rsp_rdata = 0x8000_0055; a second read returns 0x0000_0000.
- Fill RX with 16 bytes, then rx_valid 0x99 concurrent with a DATA read -> the read returns the first byte, rx_count stays 16, rx_overrun = 0. A further rx_valid with no read sets rx_overrun = 1.
- With UART_MMIO_IRQ_EN defined, CTRL = 0x1, inject one byte -> irq rises within 2 cycles and falls 2 cycles after the DATA read empties RX. Without the macro, irq stays 0.
- Assert reset mid-TX with 5 bytes queued -> tx_vld = 0 and irq = 0 immediately; STATUS reads 0x0000_0005 after release.
